// File: rtl/mul_job_dispatcher_if.sv
// Signal bundle for mul_job_dispatcher: producer push port, multiplier start/ready port,
// consumer product port. out_err is present only when MUL_DISPATCH_TIMEOUT_EN is defined.
interface mul_job_dispatcher_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic               mul_start;
    logic               mul_ready;
    logic [2*WIDTH-1:0] mul_result;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_a;
    logic [WIDTH-1:0]   out_b;
    logic [2*WIDTH-1:0] out_product;
    logic [CW-1:0]      count;
    logic               busy;
`ifdef MUL_DISPATCH_TIMEOUT_EN
    logic               out_err;
`endif

    // The dispatcher side.
    modport master (
        input  in_valid, in_a, in_b, mul_ready, mul_result, out_ready,
        output in_ready, mul_a, mul_b, mul_start, out_valid, out_a, out_b, out_product,
               count, busy
`ifdef MUL_DISPATCH_TIMEOUT_EN
        , output out_err
`endif
    );

    // Producer, multiplier and consumer side.
    modport slave (
        output in_valid, in_a, in_b, mul_ready, mul_result, out_ready,
        input  in_ready, mul_a, mul_b, mul_start, out_valid, out_a, out_b, out_product,
               count, busy
`ifdef MUL_DISPATCH_TIMEOUT_EN
        , input out_err
`endif
    );
endinterface

// File: rtl/mul_job_dispatcher.sv
// Operand FIFO feeding an 8x8 sequential multiplier one job at a time, returning tagged products.
// Define MUL_DISPATCH_TIMEOUT_EN to add the per-job timeout and the out_err flag.
module mul_job_dispatcher #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    mul_job_dispatcher_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               in_ready_q, in_ready_d;
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic               mul_start_q, mul_start_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_a_q, out_a_d, out_b_q, out_b_d;
    logic [2*WIDTH-1:0] out_product_q, out_product_d;
    logic               busy_q, busy_d;
    logic               push, pop;
    logic [2*WIDTH-1:0] head;
`ifdef MUL_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic               out_err_q, out_err_d;
`endif

    assign head = mem[rd_ptr_q];

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block infers a latch.
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        state_d       = state_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        mul_start_d   = mul_start_q;
        out_valid_d   = out_valid_q;
        out_a_d       = out_a_q;
        out_b_d       = out_b_q;
        out_product_d = out_product_q;
`ifdef MUL_DISPATCH_TIMEOUT_EN
        out_err_d     = out_err_q;
        tmo_cnt_d     = '0;
`endif

        // Occupancy comes only from registered state, so a fresh push is never popped the same edge.
        push = bus.in_valid && in_ready_q;
        pop  = (state_q == IDLE) && (count_q != '0) && bus.mul_ready;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d    = count_q + CW'(push) - CW'(pop);
        in_ready_d = (count_d < CW'(DEPTH));

        case (state_q)
            IDLE: begin
                if (pop) begin
                    mul_a_d     = head[2*WIDTH-1:WIDTH];
                    mul_b_d     = head[WIDTH-1:0];
                    mul_start_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.mul_ready) begin
                    mul_start_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (bus.mul_ready) begin
                    out_product_d = bus.mul_result;
                    out_a_d       = mul_a_q;
                    out_b_d       = mul_b_q;
                    out_valid_d   = 1'b1;
`ifdef MUL_DISPATCH_TIMEOUT_EN
                    out_err_d     = 1'b0;
`endif
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
`ifdef MUL_DISPATCH_TIMEOUT_EN
                    out_err_d   = 1'b0;
`endif
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef MUL_DISPATCH_TIMEOUT_EN
        // A job that has spent TIMEOUT cycles in ISSUE+WAIT without completing is returned as an error.
        if (state_q == ISSUE || state_q == WAIT) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (tmo_cnt_q == TW'(TIMEOUT - 1) && state_d != HOLD) begin
                mul_start_d   = 1'b0;
                out_product_d = '0;
                out_a_d       = mul_a_q;
                out_b_d       = mul_b_q;
                out_valid_d   = 1'b1;
                out_err_d     = 1'b1;
                state_d       = HOLD;
            end
        end
`endif

        busy_d = (state_d != IDLE);
    end

    // NOTE: the FIFO storage has no reset; pointers and count define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {bus.in_a, bus.in_b};
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            in_ready_q    <= 1'b0;
            state_q       <= IDLE;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            mul_start_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_a_q       <= '0;
            out_b_q       <= '0;
            out_product_q <= '0;
            busy_q        <= 1'b0;
`ifdef MUL_DISPATCH_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            out_err_q     <= 1'b0;
`endif
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            in_ready_q    <= in_ready_d;
            state_q       <= state_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            mul_start_q   <= mul_start_d;
            out_valid_q   <= out_valid_d;
            out_a_q       <= out_a_d;
            out_b_q       <= out_b_d;
            out_product_q <= out_product_d;
            busy_q        <= busy_d;
`ifdef MUL_DISPATCH_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            out_err_q     <= out_err_d;
`endif
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.mul_a       = mul_a_q;
    assign bus.mul_b       = mul_b_q;
    assign bus.mul_start   = mul_start_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_a       = out_a_q;
    assign bus.out_b       = out_b_q;
    assign bus.out_product = out_product_q;
    assign bus.count       = count_q;
    assign bus.busy        = busy_q;
`ifdef MUL_DISPATCH_TIMEOUT_EN
    assign bus.out_err     = out_err_q;
`endif
endmodule

// File: tb/tb_mul_job_dispatcher.sv
// Directed bench for mul_job_dispatcher with a behavioural 10-cycle multiplier model.
// Timeout scenario runs only when MUL_DISPATCH_TIMEOUT_EN is defined (TIMEOUT=16).
module tb_mul_job_dispatcher;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mul_job_dispatcher_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    mul_job_dispatcher #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Multiplier model: ready drops the edge after a start is seen, rises 10 edges later.
    logic        mul_ready_r  = 1'b1;
    logic [15:0] mul_result_r = '0;
    logic [15:0] model_prod   = '0;
    logic        model_stall  = 1'b0;
    logic        model_hang   = 1'b0;
    int          model_cnt    = 0;
    assign bus.mul_ready  = mul_ready_r;
    assign bus.mul_result = mul_result_r;

    always @(posedge clk) begin
        if (model_stall) begin
            mul_ready_r <= 1'b0;
            model_cnt   <= 0;
        end else if (mul_ready_r) begin
            if (bus.mul_start) begin
                mul_ready_r <= 1'b0;
                model_cnt   <= 10;
                model_prod  <= 16'(bus.mul_a) * 16'(bus.mul_b);
            end
        end else if (!model_hang) begin
            if (model_cnt <= 1) begin
                mul_ready_r  <= 1'b1;
                mul_result_r <= model_prod;
            end else begin
                model_cnt <= model_cnt - 1;
            end
        end
    end

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        logic        err;
    } res_t;

    res_t res_q[$];
    int   starts = 0;
    logic err_w;
`ifdef MUL_DISPATCH_TIMEOUT_EN
    assign err_w = bus.out_err;
`else
    assign err_w = 1'b0;
`endif

    // Records product handshakes and starts the model will accept on the coming edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid && bus.out_ready)
                res_q.push_back('{a: bus.out_a, b: bus.out_b, p: bus.out_product, err: err_w});
            if (bus.mul_start && mul_ready_r && !model_stall) starts++;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (!ok) check("push_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_results(input int n, input string tag);
        int i = 0;
        while (res_q.size() < n && i < 1000) begin
            tick();
            i++;
        end
        check({tag, "_count"}, 64'(res_q.size()), 64'(n));
    endtask

    task automatic check_res(input string tag, input int idx, input logic [7:0] a,
                             input logic [7:0] b, input logic [15:0] p, input logic e);
        res_t exp = '{a: a, b: b, p: p, err: e};
        res_t got = '1;
        if (idx < res_q.size()) got = res_q[idx];
        check(tag, 64'(got), 64'(exp));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0, s5, k, unstable;
        logic [7:0] oa [5];
        logic [7:0] ob [5];
        logic [15:0] op [5];
        oa = '{8'd3, 8'd2, 8'd3, 8'd1, 8'd0};
        ob = '{8'd4, 8'd4, 8'd3, 8'd2, 8'd0};
        op = '{16'd12, 16'd8, 16'd9, 16'd2, 16'd0};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;

        // Reset state
        reset = 1'b1;
        tick(3);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_mul_start", 64'(bus.mul_start), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_product", 64'(bus.out_product), 64'd0);
        reset = 1'b0;
        tick(1);
        check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

        // Single job
        s0 = starts;
        push(8'd3, 8'd4);
        wait_results(1, "single");
        check_res("single_res", 0, 8'd3, 8'd4, 16'h000C, 1'b0);
        tick(3);
        check("single_starts", 64'(starts - s0), 64'd1);
        check("single_count", 64'(bus.count), 64'd0);
        check("single_busy", 64'(bus.busy), 64'd0);

        // Back-to-back fill while the multiplier is held busy
        res_q.delete();
        model_stall = 1'b1;
        tick(2);
        for (int i = 0; i < 4; i++) push(oa[i], ob[i]);
        check("b2b_count_full", 64'(bus.count), 64'd4);
        check("b2b_in_ready_full", 64'(bus.in_ready), 64'd0);
        model_stall = 1'b0;
        wait_results(4, "b2b");
        for (int i = 0; i < 4; i++) check_res($sformatf("b2b_res%0d", i), i, oa[i], ob[i], op[i], 1'b0);
        tick(3);
        check("b2b_count_empty", 64'(bus.count), 64'd0);

        // Overflow: fifth job held on in_valid until the first pop frees a slot
        res_q.delete();
        s0 = starts;
        model_stall = 1'b1;
        tick(2);
        fork
            begin
                for (int i = 1; i <= 5; i++) push(8'(i), 8'(i));
                s5 = starts;
            end
            begin
                tick(12);
                model_stall = 1'b0;
            end
        join
        check("ovf_starts_at_5th", 64'(s5 - s0), 64'd1);
        wait_results(5, "ovf");
        for (int i = 1; i <= 5; i++)
            check_res($sformatf("ovf_res%0d", i), i - 1, 8'(i), 8'(i), 16'(i * i), 1'b0);
        check("ovf_starts_total", 64'(starts - s0), 64'd5);

        // Backpressure: product held stable, no new start until handshake
        res_q.delete();
        s0 = starts;
        bus.out_ready = 1'b0;
        push(8'd3, 8'd4);
        push(8'd2, 8'd4);
        k = 0;
        while (!bus.out_valid && k < 200) begin
            tick();
            k++;
        end
        check("bp_valid", 64'(bus.out_valid), 64'd1);
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.out_product !== 16'd12 ||
                bus.out_a !== 8'd3 || bus.out_b !== 8'd4) unstable++;
        end
        check("bp_unstable_cycles", 64'(unstable), 64'd0);
        check("bp_product", 64'(bus.out_product), 64'd12);
        check("bp_starts_held", 64'(starts - s0), 64'd1);
        bus.out_ready = 1'b1;
        wait_results(2, "bp");
        check_res("bp_res0", 0, 8'd3, 8'd4, 16'd12, 1'b0);
        check_res("bp_res1", 1, 8'd2, 8'd4, 16'd8, 1'b0);
        check("bp_starts_total", 64'(starts - s0), 64'd2);

        // Reset during WAIT with two jobs queued
        res_q.delete();
        push(8'd3, 8'd4);
        push(8'd2, 8'd4);
        push(8'd3, 8'd3);
        k = 0;
        while (!(bus.busy && !bus.mul_start && !bus.mul_ready) && k < 200) begin
            tick();
            k++;
        end
        check("mid_in_wait", 64'(bus.busy && !bus.mul_start && !bus.mul_ready), 64'd1);
        check("mid_count_before", 64'(bus.count), 64'd2);
        reset = 1'b1;
        model_stall = 1'b1;
        tick(1);
        check("mid_count_after", 64'(bus.count), 64'd0);
        check("mid_out_valid_after", 64'(bus.out_valid), 64'd0);
        check("mid_mul_start_after", 64'(bus.mul_start), 64'd0);
        check("mid_busy_after", 64'(bus.busy), 64'd0);
        reset = 1'b0;
        s0 = starts;
        tick(1);
        push(8'd4, 8'd3);
        tick(3);
        check("mid_no_start_while_busy", 64'(starts - s0), 64'd0);
        check("mid_queued", 64'(bus.count), 64'd1);
        model_stall = 1'b0;
        wait_results(1, "mid");
        check_res("mid_res", 0, 8'd4, 8'd3, 16'd12, 1'b0);
        tick(2);
        check("mid_no_stale_result", 64'(res_q.size()), 64'd1);
        check("mid_starts", 64'(starts - s0), 64'd1);

`ifdef MUL_DISPATCH_TIMEOUT_EN
        // Timeout: multiplier never completes
        res_q.delete();
        model_hang = 1'b1;
        push(8'd5, 8'd6);
        k = 0;
        while (!bus.mul_start && k < 100) begin
            tick();
            k++;
        end
        k = 0;
        while (!bus.out_valid && k < 100) begin
            tick();
            k++;
        end
        check("tmo_latency", 64'(k), 64'd16);
        check("tmo_err_level", 64'(bus.out_err), 64'd1);
        wait_results(1, "tmo");
        check_res("tmo_res", 0, 8'd5, 8'd6, 16'd0, 1'b1);
        model_hang = 1'b0;
        push(8'd7, 8'd8);
        wait_results(2, "tmo_next");
        check_res("tmo_next_res", 1, 8'd7, 8'd8, 16'd56, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
